bg_scroll_fetch: RTL

Consumer side of the background enable strobe: samples BG_EN every clock and issues one background-memory read per enabled cycle. It walks a BG_W x BG_H frame in raster order, applying a horizontal scroll offset that advances once per frame. Returned pixels are presented downstream as a Pix_Data/Pix_Valid stream. It sits between the BG_EN generator FSM, the background ROM/SRAM read port and the pixel compositor.

---
 rtl/bg_pkg.sv | 16 +
 rtl/bg_scroll_fetch_if.sv | 15 +
 rtl/bg_addr_gen.sv | 57 +++++
 rtl/bg_scroll_fetch.sv | 103 ++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// bg_pkg: shared types, default constants and wrap-add helper for the background fetch block.
//   No ports; imported by bg_addr_gen and bg_scroll_fetch.
package bg_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, LINE_END, DRAIN} state_t;

    localparam int BG_W    = 640;
    localparam int BG_H    = 480;
    localparam int MEM_LAT = 2;

    // Modular add for operands already below m: a single conditional subtract suffices.
    function automatic int unsigned mod_add(int unsigned a, int unsigned b, int unsigned m);
        return (a + b >= m) ? a + b - m : a + b;
    endfunction

endpackage

// File: rtl/bg_scroll_fetch_if.sv
// bg_scroll_fetch_if: background memory read port.
//   Mem_Rd   - read strobe (master -> memory)
//   Mem_Addr - read address (master -> memory)
//   Mem_Data - read data, valid MEM_LAT cycles after the Mem_Rd cycle (memory -> master)
interface bg_scroll_fetch_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
);
    logic              Mem_Rd;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Data;

    modport master (output Mem_Rd, Mem_Addr, input Mem_Data);
    modport slave  (input Mem_Rd, Mem_Addr, output Mem_Data);
endinterface

// File: rtl/bg_addr_gen.sv
// bg_addr_gen: raster walker producing the scrolled background read address.
//   clk, rst_n  - clock, asynchronous active-low reset
//   frame_init  - clear x, y and row_base for a new frame
//   step        - a read is being issued; advance to the next pixel
//   scroll_x    - current horizontal scroll offset (< BG_W)
//   addr        - row_base + wrapped column for the current pixel
//   last_col    - current pixel is the last of its line
//   last_row    - current line is the last of the frame
module bg_addr_gen #(
    parameter int BG_W   = 640,
    parameter int BG_H   = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_init,
    input  logic              step,
    input  logic [9:0]        scroll_x,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col,
    output logic              last_row
);
    import bg_pkg::*;

    localparam int XW = $clog2(BG_W);
    localparam int YW = (BG_H > 1) ? $clog2(BG_H) : 1;

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] row_base;
    logic [XW-1:0]     col;

    assign col      = XW'(mod_add(32'(x), 32'(scroll_x), BG_W));
    assign addr     = row_base + ADDR_W'(col);
    assign last_col = x == XW'(BG_W - 1);
    assign last_row = y == YW'(BG_H - 1);

    // row_base advances by BG_W per line so no multiplier is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
        end else if (frame_init) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
        end else if (step) begin
            x <= last_col ? '0 : x + XW'(1);
            if (last_col && !last_row) begin
                y        <= y + YW'(1);
                row_base <= row_base + ADDR_W'(BG_W);
            end
        end
    end

endmodule

// File: rtl/bg_scroll_fetch.sv
// bg_scroll_fetch: issues one background read per enabled cycle, walking a scrolled
// BG_W x BG_H frame in raster order, and streams the returned pixels downstream.
//   Clk, Reset_n - clock, asynchronous active-low reset
//   BG_EN        - fetch enable, level-sampled each clock
//   Frame_Start  - starts a frame (accepted in IDLE only)
//   Scroll_Step  - scroll increment applied at frame start
//   mem          - memory read port (Mem_Rd, Mem_Addr, Mem_Data)
//   Pix_Data     - pixel to compositor, qualified by Pix_Valid
//   Line_Done    - pulse after the last read of each line is issued
//   Frame_Done   - pulse once the last pixel of the frame has been delivered
//   Scroll_X     - current scroll offset
module bg_scroll_fetch #(
    parameter int BG_W    = 640,
    parameter int BG_H    = 480,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                BG_EN,
    input  logic                Frame_Start,
    input  logic [3:0]          Scroll_Step,
    bg_scroll_fetch_if.master   mem,
    output logic [DATA_W-1:0]   Pix_Data,
    output logic                Pix_Valid,
    output logic                Line_Done,
    output logic                Frame_Done,
    output logic [9:0]          Scroll_X
);
    import bg_pkg::*;

    state_t              state, state_d;
    logic                frame_init, step, frame_done_d;
    logic                last_col, last_row;
    logic [ADDR_W-1:0]   addr;
    logic [MEM_LAT-1:0]  vp;

    bg_addr_gen #(.BG_W(BG_W), .BG_H(BG_H), .ADDR_W(ADDR_W)) u_addr (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .frame_init (frame_init),
        .step       (step),
        .scroll_x   (Scroll_X),
        .addr       (addr),
        .last_col   (last_col),
        .last_row   (last_row)
    );

    always_comb begin
        state_d      = state;
        frame_init   = 1'b0;
        step         = 1'b0;
        frame_done_d = 1'b0;
        case (state)
            IDLE: if (Frame_Start) begin
                frame_init = 1'b1;
                state_d    = FETCH;
            end
            FETCH: if (BG_EN) begin
                step = 1'b1;
                if (last_col)
                    state_d = last_row ? DRAIN : LINE_END;
            end
            LINE_END: state_d = FETCH;
            // The pipeline is empty once no read is outstanding; Pix_Valid may still
            // be high for the final pixel, so Frame_Done lands one cycle after it.
            DRAIN: if (!mem.Mem_Rd && vp == '0) begin
                frame_done_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            mem.Mem_Rd   <= 1'b0;
            mem.Mem_Addr <= '0;
            vp           <= '0;
            Pix_Valid    <= 1'b0;
            Pix_Data     <= '0;
            Line_Done    <= 1'b0;
            Frame_Done   <= 1'b0;
            Scroll_X     <= '0;
        end else begin
            state      <= state_d;
            mem.Mem_Rd <= step;
            if (step)
                mem.Mem_Addr <= addr;
            Line_Done  <= step && last_col;
            Frame_Done <= frame_done_d;
            vp         <= MEM_LAT'({vp, mem.Mem_Rd});
            Pix_Valid  <= vp[MEM_LAT-1];
            if (vp[MEM_LAT-1])
                Pix_Data <= mem.Mem_Data;
            if (frame_init)
                Scroll_X <= 10'(mod_add(32'(Scroll_X), 32'(Scroll_Step), BG_W));
        end
    end

endmodule
